// File: rtl/div_16bit_if.sv
// Handshake and result bundle for the 16-bit divider.
// master: start/dividend/divisor out; slave: busy/done/quotient/remainder/dbz out.
interface div_16bit_if;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        dbz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dbz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dbz
    );
endinterface

// File: rtl/div_16bit.sv
// Unsigned 16/16 restoring shift-subtract divider, one quotient bit per cycle.
// Ports: clk, rst (async, active-high), bus (div_16bit_if.slave).
// Macro DIV_BY_ZERO_DETECT_EN: zero divisor short-cuts to DONE and raises dbz.
module div_16bit (
    input  logic        clk,
    input  logic        rst,
    div_16bit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [16:0] prem;
    logic [15:0] qsr;
    logic [15:0] dvs;
    logic        busy_r;
    logic        done_r;
    logic [15:0] quo_r;
    logic [15:0] rem_r;

    logic [16:0] shifted;
    logic [16:0] diff;
    logic        ge;
    logic [16:0] prem_nx;
    logic [15:0] qsr_nx;

    // prem never exceeds the divisor, so its top bit is always shifted out
    logic        unused_top;
    assign unused_top = prem[16];

    always_comb begin
        shifted = {prem[15:0], qsr[15]};
        diff    = shifted - {1'b0, dvs};
        ge      = (shifted >= {1'b0, dvs});
        prem_nx = ge ? diff : shifted;
        qsr_nx  = {qsr[14:0], ge};
    end

`ifdef DIV_BY_ZERO_DETECT_EN
    logic dbz_r;
    assign bus.dbz = dbz_r;
`else
    assign bus.dbz = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            prem   <= 17'd0;
            qsr    <= 16'd0;
            dvs    <= 16'd0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            quo_r  <= 16'd0;
            rem_r  <= 16'd0;
`ifdef DIV_BY_ZERO_DETECT_EN
            dbz_r  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        dvs    <= bus.divisor;
                        qsr    <= bus.dividend;
                        prem   <= 17'd0;
                        cnt    <= 4'd0;
                        busy_r <= 1'b1;
`ifdef DIV_BY_ZERO_DETECT_EN
                        if (bus.divisor == 16'd0) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                            quo_r  <= 16'hFFFF;
                            rem_r  <= bus.dividend;
                            dbz_r  <= 1'b1;
                        end else begin
                            state  <= RUN;
                        end
`else
                        state  <= RUN;
`endif
                    end
                end
                RUN: begin
                    prem <= prem_nx;
                    qsr  <= qsr_nx;
                    cnt  <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                        quo_r  <= qsr_nx;
                        rem_r  <= prem_nx[15:0];
`ifdef DIV_BY_ZERO_DETECT_EN
                        dbz_r  <= 1'b0;
`endif
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.quotient  = quo_r;
    assign bus.remainder = rem_r;
endmodule

// File: tb/tb_div_16bit.sv
// Self-checking bench for div_16bit against a plain-arithmetic model.
// Latency is counted in cycles after the start-accept edge (first cycle = 1).
module tb_div_16bit;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    div_16bit_if bus ();

    div_16bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void ref_div(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] q, output logic [15:0] r,
                                    output logic z);
        if (b == 16'd0) begin
            q = 16'hFFFF;
            r = a;
`ifdef DIV_BY_ZERO_DETECT_EN
            z = 1'b1;
`else
            z = 1'b0;
`endif
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    function automatic int ref_lat(input logic [15:0] b);
`ifdef DIV_BY_ZERO_DETECT_EN
        if (b == 16'd0) return 1;
`endif
        return 17;
    endfunction

    // Drive start for one edge, then scramble operands to prove they were latched.
    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 16'($urandom);
    endtask

    task automatic wait_done(output int lat, output int busy_bad);
        lat = 1;
        busy_bad = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy !== 1'b1) busy_bad++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (bus.busy !== 1'b1) busy_bad++;
    endtask

    task automatic check_result(input string name, input int lat, input int lat_exp,
                                input logic [15:0] q_exp, input logic [15:0] r_exp,
                                input logic z_exp);
        checks++;
        if (lat != lat_exp) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, lat_exp);
        end
        checks++;
        if (bus.quotient !== q_exp || bus.remainder !== r_exp || bus.dbz !== z_exp) begin
            errors++;
            $display("FAIL %s result: got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                     name, bus.quotient, bus.remainder, bus.dbz, q_exp, r_exp, z_exp);
        end
    endtask

    task automatic test_reset;
        bus.start = 1'b0;
        bus.dividend = 16'd0;
        bus.divisor = 16'd0;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dbz !== 1'b0 ||
            bus.quotient !== 16'h0 || bus.remainder !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b dbz=%b q=%h r=%h want all 0",
                     bus.busy, bus.done, bus.dbz, bus.quotient, bus.remainder);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int lat, bb;
        launch(16'd100, 16'd7);
        wait_done(lat, bb);
        check_result("basic_100_7", lat, 17, 16'd14, 16'd2, 1'b0);
        checks++;
        if (bb != 0 || lat != 17) begin
            errors++;
            $display("FAIL basic_busy: low cycles=%0d busy span=%0d want 0 and 17", bb, lat);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bb, c1, c2;
        launch(16'hFFFF, 16'h0001);
        wait_done(lat, bb);
        c1 = cyc;
        check_result("b2b_first", lat, 17, 16'hFFFF, 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        launch(16'hFFFF, 16'hFFFF);
        wait_done(lat, bb);
        c2 = cyc;
        check_result("b2b_second", lat, 17, 16'h0001, 16'h0000, 1'b0);
        checks++;
        if (c2 - c1 != 18) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d want 18", c2 - c1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ignore_start;
        int lat, bb, extra;
        launch(16'd5, 16'd10);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.dividend = 16'd9;
        bus.divisor = 16'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat, bb);
        check_result("ignore_run", lat + 5, 17, 16'd0, 16'd5, 1'b0);
        // pulse start in the DONE cycle as well
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        extra = 0;
        for (int i = 0; i < 25; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (extra != 0 || bus.quotient !== 16'd0 || bus.remainder !== 16'd5) begin
            errors++;
            $display("FAIL ignore_extra: busy/done cycles=%0d q=%h r=%h want 0 0000 0005",
                     extra, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_dbz;
        int lat, bb;
        logic [15:0] q, r;
        logic z;
        ref_div(16'd1234, 16'd0, q, r, z);
        launch(16'd1234, 16'd0);
        wait_done(lat, bb);
        check_result("div_zero", lat, ref_lat(16'd0), q, r, z);
        @(posedge clk);
        #1;
        launch(16'd9, 16'd4);
        wait_done(lat, bb);
        check_result("dbz_clear", lat, 17, 16'd2, 16'd1, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort;
        int lat, bb, seen;
        launch(16'd500, 16'd3);
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dbz !== 1'b0 ||
            bus.quotient !== 16'h0 || bus.remainder !== 16'h0) begin
            errors++;
            $display("FAIL abort_clear: busy=%b done=%b dbz=%b q=%h r=%h want all 0",
                     bus.busy, bus.done, bus.dbz, bus.quotient, bus.remainder);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) seen++;
        end
        rst = 1'b0;
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses want 0", seen);
        end
        launch(16'd500, 16'd3);
        wait_done(lat, bb);
        check_result("abort_rerun", lat, 17, 16'd166, 16'd2, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        int lat, bb, bad;
        logic [15:0] a, b, q, r;
        logic z;
        logic [31:0] prod;
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            a = 16'($urandom);
            unique case (i % 4)
                0: b = 16'($urandom_range(1, 15));
                1: b = 16'($urandom_range(1, 255));
                default: b = 16'($urandom_range(1, 65535));
            endcase
            ref_div(a, b, q, r, z);
            launch(a, b);
            wait_done(lat, bb);
            prod = 32'(bus.quotient) * 32'(b) + 32'(bus.remainder);
            checks++;
            if (lat != 17 || bus.quotient !== q || bus.remainder !== r ||
                prod != 32'(a) || bus.remainder >= b || bus.dbz !== 1'b0) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random %0d: %h/%h got q=%h r=%h lat=%0d want q=%h r=%h lat=17",
                             i, a, b, bus.quotient, bus.remainder, lat, q, r);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_start();
        test_dbz();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_16bit.md
DIV_16BIT -- requirements
Module: div_16bit

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock, the only clock.
REQ-002 SHALL have ports: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: start  input  1  request a divide; sampled only while idle.
REQ-004 SHALL have ports: dividend  input  16  unsigned numerator; sampled with start.
REQ-005 SHALL have ports: divisor  input  16  unsigned denominator; sampled with start.
REQ-006 SHALL have ports: busy  output  1  high from the cycle after start is accepted through the done cycle, inclusive.
REQ-007 SHALL have ports: done  output  1  single-cycle pulse marking quotient/remainder valid.
REQ-008 SHALL have ports: quotient  output  16  registered result, held until the next done.
REQ-009 SHALL have ports: remainder  output  16  registered result, held until the next done.
REQ-010 SHALL have ports: dbz  output  1  divide-by-zero flag, updated at done.
REQ-011 SHALL use one clock with asynchronous active-high reset; this is fixed.

Function
REQ-012 SHALL implement a restoring shift-subtract divider: 17-bit partial remainder and 16-bit quotient shift register, one quotient bit per RUN cycle, MSB first.
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL transition IDLE->RUN when start=1 at a clock edge; operands are latched on that same edge.
REQ-015 SHALL stay in RUN for exactly 16 cycles, with a 4-bit iteration counter running 0..15; at count 15, RUN->DONE.
REQ-016 SHALL transition DONE->IDLE unconditionally after 1 cycle.
REQ-017 SHALL assert done in the DONE cycle only, which falls 17 cycles after the start-accept edge; quotient, remainder and dbz update on entry to DONE.
REQ-018 SHALL ignore start while busy=1, including in the DONE cycle; dividend/divisor changes during RUN SHALL NOT affect the result.
REQ-019 SHALL accept start=1 in the first IDLE cycle after DONE, giving back-to-back operation every 18 cycles.
REQ-020 SHALL compute, in each RUN step: if shifted partial remainder >= divisor, subtract and set quotient bit to 1; else restore and set quotient bit to 0.
REQ-021 SHALL satisfy, for all divisor != 0: quotient*divisor + remainder == dividend and remainder < divisor.
REQ-022 SHALL produce quotient=0 and remainder=dividend when dividend < divisor.

Reset
REQ-023 SHALL, while rst=1, immediately force state=IDLE, counter=0, busy=0, done=0, dbz=0, quotient=0x0000 and remainder=0x0000, regardless of the clock.
REQ-024 SHALL abort any operation in progress when reset is asserted, producing no done pulse, with the first start accepted on the first edge after rst deasserts.

Configuration
REQ-025 SHALL support macro DIV_BY_ZERO_DETECT_EN. When defined: divisor==0 at start -> IDLE->DONE directly, done 1 cycle after accept, quotient=0xFFFF, remainder=dividend, dbz=1; dbz=0 for all other operations.
REQ-026 SHALL, when DIV_BY_ZERO_DETECT_EN is not defined: divisor==0 follows the normal 17-cycle path, yielding quotient=0xFFFF and remainder=dividend naturally; the dbz port remains present and is tied to 0.

Verification
REQ-027 SHALL cover: dividend=100, divisor=7, start for 1 cycle -> done exactly 17 cycles later, quotient=14, remainder=2, busy high for 17 cycles.
REQ-028 SHALL cover: 0xFFFF/0x0001 followed immediately by 0xFFFF/0xFFFF -> quotient=0xFFFF with remainder=0, then quotient=1 with remainder=0; second done 18 cycles after first.
REQ-029 SHALL cover: 5/10 -> quotient=0, remainder=5; while busy, pulse start with 9/3 -> ignored, result unchanged, no extra done.
REQ-030 SHALL cover: 1234/0 -> with macro: done after 1 cycle, quotient=0xFFFF, remainder=1234, dbz=1; without macro: done after 17 cycles, same quotient/remainder, dbz=0.
REQ-031 SHALL cover: start 500/3, assert rst at RUN count 8 -> all outputs 0 immediately, no done; after release, 500/3 -> quotient=166, remainder=2.
REQ-032 SHALL cover: 2000 random operand pairs with nonzero divisor -> identity in REQ-021 holds for every done.
